// File: rtl/mem_resp_pkg.sv
// Shared definitions for the memory responder.
// Contents: one-hot FSM state encoding, word/lane geometry, and a helper that
// expands a byte strobe into a bit mask.
package mem_resp_pkg;

  typedef enum logic [4:0] {
    S_IDLE = 5'b00001,
    S_DLY  = 5'b00010,
    S_ACC  = 5'b00100,
    S_RLAT = 5'b01000,
    S_RESP = 5'b10000
  } state_e;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned LANE_W     = 8;
  localparam int unsigned WORD_W     = WORD_BYTES * LANE_W;

  // Byte strobe -> bit mask, strobe bit i covers bits [8i+7:8i].
  function automatic logic [WORD_W-1:0] strb_mask(input logic [WORD_BYTES-1:0] strb);
    logic [WORD_W-1:0] m;
    m = '0;
    for (int i = 0; i < int'(WORD_BYTES); i++) begin
      m[i*LANE_W +: LANE_W] = {LANE_W{strb[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/sram_bwe.sv
// Synchronous single-port RAM, 32-bit words with per-byte write enables.
// Ports:
//   clk, rst  - clock; synchronous active-high reset (clears read register only)
//   we, wstrb - write enable and byte enables
//   re        - read enable; read data register updates only when set
//   addr      - word index
//   wdata     - write data
//   rdata     - registered read data, 1-cycle latency, write-first
module sram_bwe
  import mem_resp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WORD_W-1:0]     wdata,
  input  logic [WORD_BYTES-1:0] wstrb,
  output logic [WORD_W-1:0]     rdata
);

  logic [WORD_W-1:0] mem_q [2**ADDR_WIDTH];
  logic [WORD_W-1:0] rdata_q;
  logic [WORD_W-1:0] wmask;

  assign wmask = strb_mask(wstrb);

  // Array itself is never reset: contents survive rst.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < int'(WORD_BYTES); i++) begin
        if (wstrb[i]) begin
          mem_q[addr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  // Held between reads so the response stays stable for as long as needed.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= we ? ((mem_q[addr] & ~wmask) | (wdata & wmask)) : mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for a CPU data (or instruction) port.
// Accepts one request at a time after REQ_LAT idle cycles, performs a
// byte-masked write or a word read on the internal RAM, and returns read data
// RESP_LAT cycles after accept, held until the initiator takes it.
// Ports:
//   clk, rst        - clock; synchronous active-high reset
//   Address         - byte address, bits [1:0] and above ADDR_WIDTH+1 ignored
//   MemRead/MemWrite- request type; both high = write plus protocol error
//   Write_data/strb - write data and byte enables
//   Mem_Req_Ready   - one-cycle accept pulse
//   Read_data/Valid - read response; Read_data_Ready completes it
//   rd_cnt/wr_cnt   - accepted read/write counters (wrap)
//   proto_err       - sticky, set on simultaneous read and write
//
// state  | meaning
// IDLE   | waiting for a request
// DLY    | request seen, counting down accept latency
// ACC    | Mem_Req_Ready high; request sampled and executed on this edge
// RLAT   | read accepted, counting down response latency
// RESP   | Read_data_Valid high until Read_data_Ready
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned REQ_LAT    = 2,
  parameter int unsigned RESP_LAT   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Address,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Write_data,
  input  logic [3:0]  Write_strb,
  output logic        Mem_Req_Ready,
  output logic [31:0] Read_data,
  output logic        Read_data_Valid,
  input  logic        Read_data_Ready,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt,
  output logic        proto_err
);

  // DLY runs N cycles when loaded with N-1; RLAT runs RESP_LAT-1 cycles.
  localparam logic [7:0] REQ_INIT  = 8'((REQ_LAT  > 0) ? REQ_LAT  - 1 : 0);
  localparam logic [7:0] RESP_INIT = 8'((RESP_LAT > 1) ? RESP_LAT - 2 : 0);

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic        req_rdy_q;
  logic        valid_q;
  logic [31:0] rd_cnt_q;
  logic [31:0] wr_cnt_q;
  logic        err_q;

  logic        req;
  logic        in_acc;
  logic        ram_we;
  logic        ram_re;
  logic        unused_addr;

  assign req    = MemRead | MemWrite;
  assign in_acc = (state_q == S_ACC);
  // Gated by rst so a reset landing on the accept edge abandons the access.
  assign ram_we = in_acc & MemWrite & ~rst;
  assign ram_re = in_acc & MemRead & ~MemWrite & ~rst;

  assign unused_addr = ^{Address[31:ADDR_WIDTH+2], Address[1:0]};

  sram_bwe #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (ram_we),
    .re   (ram_re),
    .addr (Address[ADDR_WIDTH+1:2]),
    .wdata(Write_data),
    .wstrb(Write_strb),
    .rdata(Read_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      req_rdy_q <= 1'b0;
      valid_q   <= 1'b0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req) begin
            if (REQ_LAT == 0) begin
              state_q   <= S_ACC;
              req_rdy_q <= 1'b1;
            end else begin
              state_q <= S_DLY;
              cnt_q   <= REQ_INIT;
            end
          end
        end
        S_DLY: begin
          if (cnt_q == 8'd0) begin
            state_q   <= S_ACC;
            req_rdy_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        S_ACC: begin
          req_rdy_q <= 1'b0;
          if (MemWrite) begin
            wr_cnt_q <= wr_cnt_q + 32'd1;
            if (MemRead) err_q <= 1'b1;
            state_q  <= S_IDLE;
          end else if (MemRead) begin
            rd_cnt_q <= rd_cnt_q + 32'd1;
            if (RESP_LAT <= 1) begin
              state_q <= S_RESP;
              valid_q <= 1'b1;
            end else begin
              state_q <= S_RLAT;
              cnt_q   <= RESP_INIT;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RLAT: begin
          if (cnt_q == 8'd0) begin
            state_q <= S_RESP;
            valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        S_RESP: begin
          if (Read_data_Ready) begin
            valid_q <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          req_rdy_q <= 1'b0;
          valid_q   <= 1'b0;
        end
      endcase
    end
  end

  assign Mem_Req_Ready   = req_rdy_q;
  assign Read_data_Valid = valid_q;
  assign rd_cnt          = rd_cnt_q;
  assign wr_cnt          = wr_cnt_q;
  assign proto_err       = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: dut0 with REQ_LAT=2/RESP_LAT=3, dut1 with 0/0.
module tb_mem_responder;

  localparam int AW = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_s   [2];
  logic [31:0] addr    [2];
  logic        mrd     [2];
  logic        mwr     [2];
  logic [31:0] wdata   [2];
  logic [3:0]  strb    [2];
  logic        rdy_in  [2];
  logic        req_rdy [2];
  logic [31:0] rdata   [2];
  logic        vld     [2];
  logic [31:0] rdc     [2];
  logic [31:0] wrc     [2];
  logic        perr    [2];

  mem_responder #(.ADDR_WIDTH(AW), .REQ_LAT(2), .RESP_LAT(3)) dut0 (
    .clk(clk), .rst(rst_s[0]), .Address(addr[0]), .MemRead(mrd[0]), .MemWrite(mwr[0]),
    .Write_data(wdata[0]), .Write_strb(strb[0]), .Mem_Req_Ready(req_rdy[0]),
    .Read_data(rdata[0]), .Read_data_Valid(vld[0]), .Read_data_Ready(rdy_in[0]),
    .rd_cnt(rdc[0]), .wr_cnt(wrc[0]), .proto_err(perr[0])
  );

  mem_responder #(.ADDR_WIDTH(AW), .REQ_LAT(0), .RESP_LAT(0)) dut1 (
    .clk(clk), .rst(rst_s[1]), .Address(addr[1]), .MemRead(mrd[1]), .MemWrite(mwr[1]),
    .Write_data(wdata[1]), .Write_strb(strb[1]), .Mem_Req_Ready(req_rdy[1]),
    .Read_data(rdata[1]), .Read_data_Valid(vld[1]), .Read_data_Ready(rdy_in[1]),
    .rd_cnt(rdc[1]), .wr_cnt(wrc[1]), .proto_err(perr[1])
  );

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] e;
    int          bp;
  } vec_t;

  int          n_cmp = 0;
  int          n_err = 0;
  int          exp_rd [2];
  int          exp_wr [2];
  int          last_acc [2];
  logic [31:0] sb_q [$];
  vec_t        tbl [10];

  function automatic int req_lat(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic int resp_eff(input int d);
    return (d == 0) ? 3 : 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out waiting, expected event did not occur (t=%0t)", nm, $time);
  endtask

  task automatic chk_counts(input int d);
    chk("rd_cnt", 64'(rdc[d]), 64'(exp_rd[d]));
    chk("wr_cnt", 64'(wrc[d]), 64'(exp_wr[d]));
  endtask

  // One full transaction; with hold_rdy the initiator keeps Read_data_Ready high.
  task automatic do_txn(input int d, input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] dat, input logic [3:0] st, input logic [31:0] e,
                        input int bp, input bit hold_rdy);
    int n;
    logic [31:0] held;
    addr[d] = a; wdata[d] = dat; strb[d] = st; mrd[d] = rd; mwr[d] = wr;
    if (rd && !wr) sb_q.push_back(e);
    n = 0;
    do begin
      tick();
      n++;
    end while (!req_rdy[d] && n < 300);
    if (!req_rdy[d]) begin
      timeout("accept");
      mrd[d] = 1'b0; mwr[d] = 1'b0;
      if (rd && !wr) void'(sb_q.pop_back());
      return;
    end
    chk("acc_lat", 64'(n), 64'(req_lat(d) + 1));
    tick();
    last_acc[d] = cyc;
    mrd[d] = 1'b0; mwr[d] = 1'b0;
    chk("rdy_pulse", {63'd0, req_rdy[d]}, 64'd0);
    if (wr) exp_wr[d]++;
    else if (rd) exp_rd[d]++;
    if (rd && !wr) begin
      n = 1;
      while (!vld[d] && n < 300) begin
        tick();
        n++;
      end
      held = sb_q.pop_front();
      if (!vld[d]) begin
        timeout("valid");
        return;
      end
      chk("resp_lat", 64'(n), 64'(resp_eff(d)));
      chk("rdata", 64'(rdata[d]), 64'(held));
      if (bp > 0) begin
        mrd[d] = 1'b1;
        addr[d] = a + 32'h8;
        for (int i = 0; i < bp; i++) begin
          tick();
          chk("bp_hold", {30'd0, vld[d], req_rdy[d], rdata[d]}, {30'd0, 1'b1, 1'b0, held});
        end
        mrd[d] = 1'b0;
      end
      if (!hold_rdy) rdy_in[d] = 1'b1;
      tick();
      if (!hold_rdy) rdy_in[d] = 1'b0;
      chk("vld_clear", {63'd0, vld[d]}, 64'd0);
    end
    chk_counts(d);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int d = 0; d < 2; d++) begin
      rst_s[d] = 1'b1; addr[d] = '0; mrd[d] = 1'b0; mwr[d] = 1'b0;
      wdata[d] = '0; strb[d] = '0; rdy_in[d] = 1'b0;
      exp_rd[d] = 0; exp_wr[d] = 0; last_acc[d] = 0;
    end

    tbl[0] = '{rd: 0, wr: 1, a: 32'h40,   d: 32'hDEADBEEF, s: 4'b1111, e: 32'h0,        bp: 0};
    tbl[1] = '{rd: 1, wr: 0, a: 32'h40,   d: 32'h0,        s: 4'b0000, e: 32'hDEADBEEF, bp: 0};
    tbl[2] = '{rd: 0, wr: 1, a: 32'h80,   d: 32'h11223344, s: 4'b1111, e: 32'h0,        bp: 0};
    tbl[3] = '{rd: 0, wr: 1, a: 32'h80,   d: 32'hAAAAAAAA, s: 4'b0100, e: 32'h0,        bp: 0};
    tbl[4] = '{rd: 1, wr: 0, a: 32'h80,   d: 32'h0,        s: 4'b0000, e: 32'h11AA3344, bp: 10};
    tbl[5] = '{rd: 0, wr: 1, a: 32'h80,   d: 32'hFFFFFFFF, s: 4'b0000, e: 32'h0,        bp: 0};
    tbl[6] = '{rd: 1, wr: 0, a: 32'h80,   d: 32'h0,        s: 4'b0000, e: 32'h11AA3344, bp: 0};
    tbl[7] = '{rd: 0, wr: 1, a: 32'h80,   d: 32'h00000055, s: 4'b0001, e: 32'h0,        bp: 0};
    tbl[8] = '{rd: 1, wr: 0, a: 32'h80,   d: 32'h0,        s: 4'b0000, e: 32'h11AA3355, bp: 0};
    tbl[9] = '{rd: 1, wr: 0, a: 32'h4083, d: 32'h0,        s: 4'b0000, e: 32'h11AA3355, bp: 2};

    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      chk("rst_state", {29'd0, req_rdy[d], vld[d], perr[d], rdata[d]}, 64'd0);
      chk_counts(d);
    end
    rst_s[0] = 1'b0; rst_s[1] = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) begin
      do_txn(0, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].s, tbl[i].e, tbl[i].bp, 1'b0);
    end

    // Zero latency: Ready held high throughout, must be ignored outside RESP.
    rdy_in[1] = 1'b1;
    do_txn(1, 0, 1, 32'h0, 32'hA5A50001, 4'hF, 32'h0, 0, 1'b1);
    do_txn(1, 0, 1, 32'h4, 32'h5A5A0002, 4'hF, 32'h0, 0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      int prev;
      prev = last_acc[1];
      do_txn(1, 1, 0, (i % 2 == 0) ? 32'h0 : 32'h4, 32'h0, 4'h0,
             (i % 2 == 0) ? 32'hA5A50001 : 32'h5A5A0002, 0, 1'b1);
      if (i > 0) chk("turnaround", 64'(last_acc[1] - prev), 64'd3);
    end
    rdy_in[1] = 1'b0;

    // Reset during DLY of a write.
    do_txn(0, 0, 1, 32'h10, 32'h00000077, 4'hF, 32'h0, 0, 1'b0);
    do_txn(0, 1, 0, 32'h10, 32'h0, 4'h0, 32'h00000077, 0, 1'b0);
    addr[0] = 32'h10; wdata[0] = 32'h5; strb[0] = 4'hF; mwr[0] = 1'b1;
    tick();
    rst_s[0] = 1'b1;
    tick();
    chk("rst_mid", {29'd0, req_rdy[0], vld[0], perr[0], rdata[0]}, 64'd0);
    exp_rd[0] = 0; exp_wr[0] = 0;
    chk_counts(0);
    rst_s[0] = 1'b0; mwr[0] = 1'b0;
    tick();

    // Reset landing on the accept edge of a write.
    addr[0] = 32'h10; wdata[0] = 32'h9; strb[0] = 4'hF; mwr[0] = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!req_rdy[0] && n < 300);
    if (!req_rdy[0]) timeout("acc_reset");
    rst_s[0] = 1'b1;
    tick();
    rst_s[0] = 1'b0; mwr[0] = 1'b0;
    tick();
    do_txn(0, 1, 0, 32'h10, 32'h0, 4'h0, 32'h00000077, 0, 1'b0);

    // Read and write together: write only, sticky error, no response.
    do_txn(0, 1, 1, 32'h20, 32'h12345678, 4'hF, 32'h0, 0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("proto_no_vld", {63'd0, vld[0]}, 64'd0);
    end
    chk("proto_err", {63'd0, perr[0]}, 64'd1);
    do_txn(0, 1, 0, 32'h20 + (32'd4 << AW), 32'h0, 4'h0, 32'h12345678, 0, 1'b0);
    chk("proto_sticky", {63'd0, perr[0]}, 64'd1);
    rst_s[0] = 1'b1;
    tick();
    rst_s[0] = 1'b0;
    chk("proto_clr", {63'd0, perr[0]}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
